// File: rtl/cdb_arb.sv
// cdb_arb - common data bus slot arbiter.
//
// Up to four completing functional units are selected each cycle and granted
// combinationally. Their PR tag, AR tag and result are registered and
// broadcast on the four CDB slots in the following cycle. Winners are packed
// into slots from 0 upward in scan order; unused slots read as all-zero with
// their broadcast bit low.
//
// Configuration macro: CDB_ARB_RR_EN
//   defined   : round-robin scan starting at rr_ptr; rr_ptr advances past the
//               last granted FU.
//   undefined : fixed priority, scan always starts at FU 0 (no pointer state).
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   branch_recover      flush: no grants this cycle, empty broadcast next cycle
//   fu_req              per-FU request
//   fu_pr_tag/ar_tag/   packed per-FU payload, FU i at [i*W +: W]
//   fu_result
//   fu_grant            per-FU grant (combinational)
//   cdb_broadcast       registered slot valid bits
//   cdb_pr_tag0..3,     registered slot payloads
//   cdb_ar_tag0..3,
//   cdb_value0..3

module cdb_arb #(
  parameter int NUM_FU = 8,
  parameter int PR_W   = 7,
  parameter int AR_W   = 5,
  parameter int DATA_W = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     branch_recover,
  input  logic [NUM_FU-1:0]        fu_req,
  input  logic [NUM_FU*PR_W-1:0]   fu_pr_tag,
  input  logic [NUM_FU*AR_W-1:0]   fu_ar_tag,
  input  logic [NUM_FU*DATA_W-1:0] fu_result,
  output logic [NUM_FU-1:0]        fu_grant,
  output logic [3:0]               cdb_broadcast,
  output logic [PR_W-1:0]          cdb_pr_tag0,
  output logic [PR_W-1:0]          cdb_pr_tag1,
  output logic [PR_W-1:0]          cdb_pr_tag2,
  output logic [PR_W-1:0]          cdb_pr_tag3,
  output logic [AR_W-1:0]          cdb_ar_tag0,
  output logic [AR_W-1:0]          cdb_ar_tag1,
  output logic [AR_W-1:0]          cdb_ar_tag2,
  output logic [AR_W-1:0]          cdb_ar_tag3,
  output logic [DATA_W-1:0]        cdb_value0,
  output logic [DATA_W-1:0]        cdb_value1,
  output logic [DATA_W-1:0]        cdb_value2,
  output logic [DATA_W-1:0]        cdb_value3
);

  localparam int NUM_SLOT = 4;

  logic [NUM_SLOT-1:0] slot_vld_d, slot_vld_q;
  logic [PR_W-1:0]     slot_pr_d  [NUM_SLOT];
  logic [PR_W-1:0]     slot_pr_q  [NUM_SLOT];
  logic [AR_W-1:0]     slot_ar_d  [NUM_SLOT];
  logic [AR_W-1:0]     slot_ar_q  [NUM_SLOT];
  logic [DATA_W-1:0]   slot_val_d [NUM_SLOT];
  logic [DATA_W-1:0]   slot_val_q [NUM_SLOT];

  logic [2:0] n_slot;
  int         idx;
  int         scan_start;

`ifdef CDB_ARB_RR_EN
  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [PTR_W-1:0] rr_ptr_d, rr_ptr_q;
  logic             any_grant;
  int               last_idx;

  assign scan_start = int'(rr_ptr_q);
`else
  assign scan_start = 0;
`endif

  // Walk the FUs once in scan order, handing out slots until four are used.
  // Reset and recover both suppress every grant, which also leaves the slot
  // inputs at zero so the next broadcast is empty.
  always_comb begin
    fu_grant   = '0;
    slot_vld_d = '0;
    for (int s = 0; s < NUM_SLOT; s++) begin
      slot_pr_d[s]  = '0;
      slot_ar_d[s]  = '0;
      slot_val_d[s] = '0;
    end
    n_slot = 3'd0;
    idx    = 0;
`ifdef CDB_ARB_RR_EN
    any_grant = 1'b0;
    last_idx  = 0;
`endif
    if (!reset && !branch_recover) begin
      for (int k = 0; k < NUM_FU; k++) begin
        idx = scan_start + k;
        if (idx >= NUM_FU) idx = idx - NUM_FU;
        if (fu_req[idx] && (n_slot < 3'd4)) begin
          fu_grant[idx]                = 1'b1;
          slot_vld_d[n_slot[1:0]]      = 1'b1;
          slot_pr_d[n_slot[1:0]]       = fu_pr_tag[idx*PR_W +: PR_W];
          slot_ar_d[n_slot[1:0]]       = fu_ar_tag[idx*AR_W +: AR_W];
          slot_val_d[n_slot[1:0]]      = fu_result[idx*DATA_W +: DATA_W];
          n_slot                       = n_slot + 3'd1;
`ifdef CDB_ARB_RR_EN
          any_grant = 1'b1;
          last_idx  = idx;
`endif
        end
      end
    end
  end

`ifdef CDB_ARB_RR_EN
  // Next scan starts just past the last winner so losers move to the front.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any_grant) begin
      if (last_idx >= NUM_FU - 1) rr_ptr_d = '0;
      else                        rr_ptr_d = PTR_W'(last_idx + 1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_vld_q <= '0;
      for (int s = 0; s < NUM_SLOT; s++) begin
        slot_pr_q[s]  <= '0;
        slot_ar_q[s]  <= '0;
        slot_val_q[s] <= '0;
      end
    end else begin
      slot_vld_q <= slot_vld_d;
      for (int s = 0; s < NUM_SLOT; s++) begin
        slot_pr_q[s]  <= slot_pr_d[s];
        slot_ar_q[s]  <= slot_ar_d[s];
        slot_val_q[s] <= slot_val_d[s];
      end
    end
  end

  assign cdb_broadcast = slot_vld_q;
  assign cdb_pr_tag0   = slot_pr_q[0];
  assign cdb_pr_tag1   = slot_pr_q[1];
  assign cdb_pr_tag2   = slot_pr_q[2];
  assign cdb_pr_tag3   = slot_pr_q[3];
  assign cdb_ar_tag0   = slot_ar_q[0];
  assign cdb_ar_tag1   = slot_ar_q[1];
  assign cdb_ar_tag2   = slot_ar_q[2];
  assign cdb_ar_tag3   = slot_ar_q[3];
  assign cdb_value0    = slot_val_q[0];
  assign cdb_value1    = slot_val_q[1];
  assign cdb_value2    = slot_val_q[2];
  assign cdb_value3    = slot_val_q[3];

endmodule

// File: tb/tb_cdb_arb.sv
module tb_cdb_arb;

  localparam int N      = 8;
  localparam int PR_W   = 7;
  localparam int AR_W   = 5;
  localparam int DATA_W = 64;
`ifdef CDB_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic                clock = 1'b0;
  logic                reset;
  logic                branch_recover;
  logic [N-1:0]        fu_req;
  logic [N*PR_W-1:0]   fu_pr_tag;
  logic [N*AR_W-1:0]   fu_ar_tag;
  logic [N*DATA_W-1:0] fu_result;
  logic [N-1:0]        fu_grant;
  logic [3:0]          cdb_broadcast;
  logic [PR_W-1:0]     cdb_pr_tag0, cdb_pr_tag1, cdb_pr_tag2, cdb_pr_tag3;
  logic [AR_W-1:0]     cdb_ar_tag0, cdb_ar_tag1, cdb_ar_tag2, cdb_ar_tag3;
  logic [DATA_W-1:0]   cdb_value0, cdb_value1, cdb_value2, cdb_value3;

  logic [PR_W-1:0]   pr_in  [N];
  logic [AR_W-1:0]   ar_in  [N];
  logic [DATA_W-1:0] val_in [N];

  logic [PR_W-1:0]   o_pr  [4];
  logic [AR_W-1:0]   o_ar  [4];
  logic [DATA_W-1:0] o_val [4];

  int checks = 0;
  int errors = 0;

  // reference model state and expectations
  int                m_ptr;
  logic [N-1:0]      m_grant;
  logic [3:0]        e_bc;
  logic [PR_W-1:0]   e_pr  [4];
  logic [AR_W-1:0]   e_ar  [4];
  logic [DATA_W-1:0] e_val [4];

  always #5 clock = ~clock;

  always_comb begin
    fu_pr_tag = '0;
    fu_ar_tag = '0;
    fu_result = '0;
    for (int i = 0; i < N; i++) begin
      fu_pr_tag[i*PR_W +: PR_W]     = pr_in[i];
      fu_ar_tag[i*AR_W +: AR_W]     = ar_in[i];
      fu_result[i*DATA_W +: DATA_W] = val_in[i];
    end
  end

  assign o_pr[0] = cdb_pr_tag0;  assign o_pr[1] = cdb_pr_tag1;
  assign o_pr[2] = cdb_pr_tag2;  assign o_pr[3] = cdb_pr_tag3;
  assign o_ar[0] = cdb_ar_tag0;  assign o_ar[1] = cdb_ar_tag1;
  assign o_ar[2] = cdb_ar_tag2;  assign o_ar[3] = cdb_ar_tag3;
  assign o_val[0] = cdb_value0;  assign o_val[1] = cdb_value1;
  assign o_val[2] = cdb_value2;  assign o_val[3] = cdb_value3;

  cdb_arb #(.NUM_FU(N), .PR_W(PR_W), .AR_W(AR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset), .branch_recover(branch_recover),
    .fu_req(fu_req), .fu_pr_tag(fu_pr_tag), .fu_ar_tag(fu_ar_tag),
    .fu_result(fu_result), .fu_grant(fu_grant), .cdb_broadcast(cdb_broadcast),
    .cdb_pr_tag0(cdb_pr_tag0), .cdb_pr_tag1(cdb_pr_tag1),
    .cdb_pr_tag2(cdb_pr_tag2), .cdb_pr_tag3(cdb_pr_tag3),
    .cdb_ar_tag0(cdb_ar_tag0), .cdb_ar_tag1(cdb_ar_tag1),
    .cdb_ar_tag2(cdb_ar_tag2), .cdb_ar_tag3(cdb_ar_tag3),
    .cdb_value0(cdb_value0), .cdb_value1(cdb_value1),
    .cdb_value2(cdb_value2), .cdb_value3(cdb_value3)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Queue of requesters in scan order; the first four win, in that order.
  task automatic model_arb(input logic [N-1:0] req, input logic rec);
    int order[$];
    int start, n;
    m_grant = '0;
    e_bc    = '0;
    for (int s = 0; s < 4; s++) begin
      e_pr[s] = '0; e_ar[s] = '0; e_val[s] = '0;
    end
    if (rec) return;
    start = RR ? m_ptr : 0;
    for (int k = 0; k < N; k++)
      if (req[(start + k) % N]) order.push_back((start + k) % N);
    n = (order.size() < 4) ? order.size() : 4;
    for (int s = 0; s < n; s++) begin
      m_grant[order[s]] = 1'b1;
      e_bc[s]  = 1'b1;
      e_pr[s]  = pr_in[order[s]];
      e_ar[s]  = ar_in[order[s]];
      e_val[s] = val_in[order[s]];
    end
    if (n > 0) m_ptr = (order[n-1] + 1) % N;
  endtask

  task automatic chk_cdb(input string tag);
    chk({tag, ".bcast"}, 64'(cdb_broadcast), 64'(e_bc));
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("%s.pr%0d", tag, s),  64'(o_pr[s]),  64'(e_pr[s]));
      chk($sformatf("%s.ar%0d", tag, s),  64'(o_ar[s]),  64'(e_ar[s]));
      chk($sformatf("%s.val%0d", tag, s), o_val[s], e_val[s]);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_default_payload();
    for (int i = 0; i < N; i++) begin
      pr_in[i]  = PR_W'(8*i + 1);
      ar_in[i]  = AR_W'(i + 20);
      val_in[i] = 64'hCAFE_0000_0000_0000 | 64'(i);
    end
  endtask

  typedef struct {
    logic [N-1:0]    req;
    logic            rec;
    logic [N-1:0]    g_rr;
    logic [N-1:0]    g_fp;
    logic [3:0]      bc;
    logic [PR_W-1:0] pr0_rr;
    logic [PR_W-1:0] pr0_fp;
  } vec_t;

  vec_t vec [10];

  initial begin
    logic [N-1:0] pending;
    logic [N-1:0] exp_g;
    logic [PR_W-1:0] exp_pr0;

    vec[0] = '{8'hFF, 1'b0, 8'h0F, 8'h0F, 4'hF, 7'd1,  7'd1};
    vec[1] = '{8'hFF, 1'b0, 8'hF0, 8'h0F, 4'hF, 7'd33, 7'd1};
    vec[2] = '{8'h24, 1'b0, 8'h24, 8'h24, 4'h3, 7'd17, 7'd17};
    vec[3] = '{8'hC3, 1'b0, 8'hC3, 8'hC3, 4'hF, 7'd49, 7'd1};
    vec[4] = '{8'h0F, 1'b1, 8'h00, 8'h00, 4'h0, 7'd0,  7'd0};
    vec[5] = '{8'h0F, 1'b0, 8'h0F, 8'h0F, 4'hF, 7'd17, 7'd1};
    vec[6] = '{8'h00, 1'b0, 8'h00, 8'h00, 4'h0, 7'd0,  7'd0};
    vec[7] = '{8'h81, 1'b0, 8'h81, 8'h81, 4'h3, 7'd57, 7'd1};
    vec[8] = '{8'hFE, 1'b0, 8'h1E, 8'h1E, 4'hF, 7'd9,  7'd9};
    vec[9] = '{8'hFF, 1'b0, 8'hE1, 8'h0F, 4'hF, 7'd41, 7'd1};

    set_default_payload();
    reset = 1'b1;
    branch_recover = 1'b0;
    fu_req = 8'hFF;
    m_ptr = 0;
    step();
    step();
    chk("rst.grant", 64'(fu_grant), 64'h0);
    model_arb(8'h00, 1'b1);
    chk_cdb("rst");
    reset = 1'b0;

    // table vectors from a fresh reset
    for (int v = 0; v < 10; v++) begin
      fu_req = vec[v].req;
      branch_recover = vec[v].rec;
      #1;
      exp_g   = RR ? vec[v].g_rr : vec[v].g_fp;
      exp_pr0 = RR ? vec[v].pr0_rr : vec[v].pr0_fp;
      model_arb(vec[v].req, vec[v].rec);
      chk($sformatf("vec%0d.grant", v), 64'(fu_grant), 64'(exp_g));
      step();
      chk($sformatf("vec%0d.bcast", v), 64'(cdb_broadcast), 64'(vec[v].bc));
      chk($sformatf("vec%0d.pr0", v), 64'(cdb_pr_tag0), 64'(exp_pr0));
      chk_cdb($sformatf("vec%0d", v));
    end

    // two requesters with specific tags, packed into slots 0 and 1
    pr_in[2] = 7'd12;
    pr_in[5] = 7'd45;
    fu_req = 8'b0010_0100;
    branch_recover = 1'b0;
    #1;
    model_arb(fu_req, 1'b0);
    chk("two.grant", 64'(fu_grant), 64'h24);
    step();
    chk("two.bcast", 64'(cdb_broadcast), 64'h3);
    chk("two.pr0", 64'(cdb_pr_tag0), 64'd12);
    chk("two.pr1", 64'(cdb_pr_tag1), 64'd45);
    fu_req = '0;
    #1;
    model_arb(fu_req, 1'b0);
    step();
    chk("idle.bcast", 64'(cdb_broadcast), 64'h0);
    set_default_payload();

    // asynchronous reset between edges clears the bus immediately
    fu_req = 8'hFF;
    #1;
    model_arb(fu_req, 1'b0);
    step();
    chk("pre_arst.bcast", 64'(cdb_broadcast), 64'hF);
    #2;
    reset = 1'b1;
    #1;
    chk("arst.bcast", 64'(cdb_broadcast), 64'h0);
    chk("arst.pr0", 64'(cdb_pr_tag0), 64'h0);
    chk("arst.val3", cdb_value3, 64'h0);
    chk("arst.grant", 64'(fu_grant), 64'h0);
    step();
    reset = 1'b0;
    m_ptr = 0;
    #1;
    model_arb(fu_req, 1'b0);
    chk("post_arst.grant", 64'(fu_grant), 64'h0F);
    step();
    chk_cdb("post_arst");

    // randomized traffic obeying the hold-until-granted handshake
    pending = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pending[i] && ($urandom_range(0, 1) == 1)) begin
          pending[i] = 1'b1;
          pr_in[i]  = PR_W'($urandom);
          ar_in[i]  = ($urandom_range(0, 7) == 0) ? AR_W'(31) : AR_W'($urandom);
          val_in[i] = {$urandom, $urandom};
        end
      end
      fu_req = pending;
      branch_recover = ($urandom_range(0, 15) == 0);
      #1;
      model_arb(fu_req, branch_recover);
      chk($sformatf("rnd%0d.grant", c), 64'(fu_grant), 64'(m_grant));
      pending = pending & ~m_grant;
      step();
      chk_cdb($sformatf("rnd%0d", c));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arb.md
# cdb_arb

Arbiter that shares the four common data bus (CDB) slots among the functional units of the out-of-order core. Each cycle it selects up to four completing functional units and grants them. At the next clock edge it drives their physical tag, architectural tag and result onto the registered CDB outputs. The map table, reservation stations, ROB and register file all consume those outputs.

## Interface
Parameters:
- NUM_FU, 8, number of requesting functional units (4..16)
- PR_W, 7, physical register tag width
- AR_W, 5, architectural register tag width
- DATA_W, 64, result width

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- branch_recover  in  1  mispredict flush; kills this cycle's grants and next cycle's broadcast
- fu_req  in  NUM_FU  bit i = FU i has a completed result
- fu_pr_tag  in  NUM_FU*PR_W  packed destination PR tags, FU i at [i*PR_W +: PR_W]
- fu_ar_tag  in  NUM_FU*AR_W  packed destination AR tags
- fu_result  in  NUM_FU*DATA_W  packed results
- fu_grant  out  NUM_FU  bit i = FU i wins a slot this cycle (combinational)
- cdb_broadcast  out  4  slot valid bits, registered
- cdb_pr_tag0..3  out  PR_W each  slot PR tags, registered
- cdb_ar_tag0..3  out  AR_W each  slot AR tags, registered
- cdb_value0..3  out  DATA_W each  slot results, registered

## Operation
- State: round-robin pointer rr_ptr (log2(NUM_FU) bits) plus the CDB output registers.
- Scan order: FU rr_ptr, rr_ptr+1, … mod NUM_FU. The first min(4, popcount(fu_req)) requesters in scan order are granted.
- Granted FUs fill slots packed from 0: the first winner in scan order goes to slot 0, the next to slot 1, and so on. Unused slots have cdb_broadcast bit 0, and their tag/value registers are driven to 0.
- Requester handshake: an FU holds fu_req and its payload stable until it sees fu_grant high in that same cycle. On the following cycle it either drops the request or presents a new result. A request that is not granted is never lost.
- Pointer update at a clock edge with at least one grant and branch_recover=0: rr_ptr moves to (index of last granted FU + 1) mod NUM_FU. With no grants, rr_ptr is unchanged.
- branch_recover=1: fu_grant is forced to all-zero. At the edge, cdb_broadcast is cleared to 0 and rr_ptr is held.
- The arbiter does not filter AR tag 31 (zero register). Consumers handle it.

## Timing
- Reset (async): cdb_broadcast=0, all cdb_pr_tag/ar_tag/value=0, rr_ptr=0. fu_grant is 0 while reset is high.
- Grant latency: 0 cycles. fu_grant is combinational from fu_req, rr_ptr and branch_recover.
- Broadcast latency: 1 cycle. The payload granted in cycle N appears on the CDB in cycle N+1 and is held for exactly one cycle.
- Every cycle with no grants leaves cdb_broadcast=0 in the next cycle. Outputs never hold a stale broadcast.
- Wrap-around: the scan passes from FU NUM_FU-1 to FU 0. A pointer update past NUM_FU-1 wraps to 0.
- Fewer than 4 requesters: all are granted in the same cycle.
- Reset asserted mid-operation clears the outputs immediately, regardless of the clock.

## Configuration
- CDB_ARB_RR_EN defined: round-robin arbitration as described above.
- CDB_ARB_RR_EN undefined: fixed priority with FU 0 highest. The scan always starts at FU 0, rr_ptr is removed, and the slot packing and latency rules are unchanged.

## Test plan
- Reset: assert reset with fu_req=8'hFF -> fu_grant=0, cdb_broadcast=0, all tags and values 0. First clock after release -> grants for FU0..3.
- Fewer than 4 requesters: fu_req=8'b0010_0100 with PR tags 12 and 45 -> fu_grant=8'b0010_0100. Next cycle cdb_broadcast=4'b0011, cdb_pr_tag0=12, cdb_pr_tag1=45.
- Oversubscription and fairness (RR on): fu_req=8'hFF held for 2 cycles -> cycle 0 grants FU0..3, cycle 1 grants FU4..7, rr_ptr returns to 0.
- Wrap-around: rr_ptr=6, fu_req=8'b1100_0011 -> grants FU6,7,0,1 in slots 0..3, new rr_ptr=2.
- Recover: fu_req=8'h0F with branch_recover=1 -> fu_grant=0, next cycle cdb_broadcast=0, rr_ptr unchanged. With recover dropped and requests held -> FU0..3 granted.
- Fixed priority (macro off): fu_req=8'hFF for 2 cycles -> FU0..3 granted both cycles.
